ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Round-robin arbiter sharing the 16 KiB single-port RAM (14-bit address, 8-bit data, synchronous write/read, 1-cycle registered read data) among NREQ requesters. It accepts one request per cycle through a valid/ready handshake and drives the RAM command from a registered stage. It returns read data to the originating requester in order. It sits between the RAM instance and its client blocks, and is the only driver of the RAM ports.

## Interface
- NREQ, 2, number of requesters; legal range 2..8
- ADDR_W, 14, RAM address width (from package)
- DATA_W, 8, RAM data width (from package)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request pending, one bit per requester
- req_ready  out  NREQ  one-hot grant; a handshake occurs when valid and ready are both high
- req_we  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*ADDR_W  flattened addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  flattened write data
- rsp_valid  out  NREQ  one-hot, high for exactly one cycle per accepted read
- rsp_rdata  out  DATA_W  read data, valid while any rsp_valid bit is high
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM registered read data

## Operation
- **Arbitration (combinational, cycle N):**
  - Scan req_valid starting at rr_ptr, moving upward modulo NREQ.
  - The first set bit wins, and only that bit of req_ready goes high.
  - No valid request means req_ready = 0.
  - req_ready never depends on the winner's req_valid being held; the requester must keep its signals stable until the handshake completes.
- **Pointer:** on a handshake with requester i, rr_ptr <= (i+1) mod NREQ. With no grant, rr_ptr holds. Reset value of rr_ptr is 0.
- **Command stage:**
  - On a handshake, register we, addr, wdata and the winner id, and set cmd_valid.
  - The registered values drive ram_we/ram_addr/ram_wdata during cycle N+1. ram_we = cmd_valid & cmd_we.
  - Idle cycles: ram_we = 0 and ram_addr holds its last value. The harmless RAM read of the held address is discarded.
- **Response stage:**
  - A read command in N+1 sets rsp_pend and rsp_id at the end of N+1.
  - During N+2, rsp_valid[rsp_id] = 1 and rsp_rdata = ram_rdata (pass-through).
- **Writes** produce no response.
- **Throughput** is one request per cycle. Responses return in acceptance order.
- **Read-after-write:** a write accepted at N followed by a read of the same address accepted at N+1 returns the new data.
- **Requesters** must accept responses unconditionally; there is no response backpressure.
- **Reset, including mid-operation:**
  - cmd_valid, rsp_pend and rr_ptr clear.
  - In-flight requests are dropped.
  - All outputs go to 0.
  - No response is issued for a request accepted before reset.

## Timing
- Read latency is 2 cycles from handshake to rsp_valid (handshake N, response N+2).
- Write commits at the clk edge ending cycle N+1.
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0 (gated by rsp_pend), ram_we 0, ram_addr 0, ram_wdata 0.
- Grant is combinational from req_valid and rr_ptr. There is no combinational path from req_valid to any RAM port.
- State: cmd_valid/cmd_we/cmd_addr/cmd_wdata/cmd_id, rsp_pend/rsp_id, rr_ptr. There is no explicit FSM beyond the two pipeline valid bits.

## Structure
- **Package ram_arb_pkg:**
  - ADDR_W = 14, DATA_W = 8, DEPTH = 2**14.
  - typedef struct packed { logic we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] wdata; } ram_cmd_t.
  - Function next_ptr(idx, nreq).
- **Sub-module rr_arbiter (NREQ):** holds rr_ptr. Inputs are req and advance; outputs are the one-hot grant and the encoded grant id. It is reusable by other shared resources.
- **Top ram_arbiter** contains the flattened-port unpacking, the command register and the response tracking.

## Test plan
- After reset release, req0 reads addr 0x0000 at cycle N -> req_ready = 0b01 at N, rsp_valid = 0b01 at N+2 with rsp_rdata 0x00. All outputs are 0 during reset.
- req1 writes 0x3FFF=0xA5 at N, req0 reads 0x3FFF at N+1 -> ram_we high only in N+1, rsp_valid[0] at N+3 with 0xA5.
- NREQ=2, both requesters hold valid reads for 6 cycles -> grants 0,1,0,1,0,1. The 6 responses are in order, each on the matching rsp_valid bit two cycles after its grant.
- NREQ=4, rr_ptr=2 (after a grant to 1), requesters 1 and 3 valid -> grant 3, then 1, then 3.
- Read accepted at N, rstn asserted during N+1 -> no rsp_valid at N+2, ram_we = 0. The first request after release is granted to requester 0 priority.
- Continuous back-to-back reads of addresses 0x0010..0x0017 preloaded with 0x10..0x17 -> rsp_valid every cycle, returning data 0x10..0x17 in order.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared RAM geometry, command type and round-robin helper
package ram_arb_pkg;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

    function automatic int next_ptr(input int idx, input int nreq);
        return (idx + 1) % nreq;
    endfunction
endpackage

// File: rtl/ram_arbiter_rr.sv
// rr_arbiter: round-robin grant over NREQ requests, pointer advances past each winner
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    input  logic                    advance,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_id
);
    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    // scan downward so the request nearest rr_ptr (wrapping upward) is the last to win
    always_comb begin
        grant    = '0;
        grant_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr_q) + k) % NREQ]) begin
                grant                                = '0;
                grant[(int'(rr_ptr_q) + k) % NREQ]   = 1'b1;
                grant_id                             = IW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
        rr_ptr_d = advance ? IW'(next_ptr(int'(grant_id), NREQ)) : rr_ptr_q;
    end

    // pointer register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rr_ptr_q <= '0;
        else       rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one single-port RAM with in-order read responses
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    input  logic [DATA_W-1:0]      ram_rdata
);
    localparam int IW = $clog2(NREQ);

    ram_cmd_t        req_cmd [NREQ];
    ram_cmd_t        cmd_q, cmd_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic            rsp_pend_q, rsp_pend_d;
    logic [IW-1:0]   cmd_id_q, cmd_id_d, rsp_id_q, rsp_id_d;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_id;
    logic            hs;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_cmd[i] = {req_we[i], req_addr[i*ADDR_W +: ADDR_W], req_wdata[i*DATA_W +: DATA_W]};
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req_valid),
        .advance  (hs),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = grant & {NREQ{rstn}};
    assign hs        = |req_ready;
    assign ram_we    = cmd_valid_q & cmd_q.we;
    assign ram_addr  = cmd_q.addr;
    assign ram_wdata = cmd_q.wdata;
    assign rsp_valid = rsp_pend_q ? NREQ'(1) << rsp_id_q : '0;
    assign rsp_rdata = rsp_pend_q ? ram_rdata : '0;

    // capture the winner into the command stage; a read in flight becomes a pending response
    always_comb begin
        cmd_valid_d = hs;
        cmd_d       = hs ? req_cmd[grant_id] : cmd_q;
        cmd_id_d    = hs ? grant_id : cmd_id_q;
        rsp_pend_d  = cmd_valid_q & ~cmd_q.we;
        rsp_id_d    = cmd_valid_q ? cmd_id_q : rsp_id_q;
    end

    // pipeline registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_valid_q <= 1'b0;
            cmd_q       <= '0;
            cmd_id_q    <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            cmd_valid_q <= cmd_valid_d;
            cmd_q       <= cmd_d;
            cmd_id_q    <= cmd_id_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_id_q    <= rsp_id_d;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: NREQ=4 and NREQ=2 instances checked each cycle against a transaction-level model
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    typedef struct {
        int         d;
        int         due;
        int         id;
        logic [7:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bit         s_v  [2][4];
    bit         s_we [2][4];
    logic [13:0] s_a [2][4];
    logic [7:0] s_wd [2][4];

    logic [3:0]  v4, we4, rdy4, rv4;
    logic [55:0] a4;
    logic [31:0] wd4;
    logic [1:0]  v2, we2, rdy2, rv2;
    logic [27:0] a2;
    logic [15:0] wd2;
    logic [7:0]  rd4, rd2, mrd4, mrd2, rw4, rw2;
    logic [13:0] ra4, ra2;
    logic        rwe4, rwe2;

    logic        pre_en = 1'b0;
    logic [13:0] pre_a = '0;
    logic [7:0]  pre_d = '0;
    logic [7:0]  mem4 [DEPTH];
    logic [7:0]  mem2 [DEPTH];

    int         tests = 0, fails = 0, cyc = 0;
    int         ptr [2];
    int         g_last [2];
    logic       cur_we [2], nxt_we [2];
    logic [13:0] cur_a [2], nxt_a [2];
    logic [7:0] cur_wd [2], nxt_wd [2];
    logic [7:0] ref_mem [2][DEPTH];
    rsp_t       rq [$];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            v4[i] = s_v[0][i];
            we4[i] = s_we[0][i];
            a4[i*14 +: 14] = s_a[0][i];
            wd4[i*8 +: 8] = s_wd[0][i];
        end
        for (int i = 0; i < 2; i++) begin
            v2[i] = s_v[1][i];
            we2[i] = s_we[1][i];
            a2[i*14 +: 14] = s_a[1][i];
            wd2[i*8 +: 8] = s_wd[1][i];
        end
    end

    ram_arbiter #(.NREQ(4)) u4 (
        .clk(clk), .rstn(rstn), .req_valid(v4), .req_ready(rdy4), .req_we(we4),
        .req_addr(a4), .req_wdata(wd4), .rsp_valid(rv4), .rsp_rdata(rd4),
        .ram_we(rwe4), .ram_addr(ra4), .ram_wdata(rw4), .ram_rdata(mrd4)
    );

    ram_arbiter #(.NREQ(2)) u2 (
        .clk(clk), .rstn(rstn), .req_valid(v2), .req_ready(rdy2), .req_we(we2),
        .req_addr(a2), .req_wdata(wd2), .rsp_valid(rv2), .rsp_rdata(rd2),
        .ram_we(rwe2), .ram_addr(ra2), .ram_wdata(rw2), .ram_rdata(mrd2)
    );

    // behavioural single-port RAMs with registered read, plus a preload port
    always @(posedge clk) begin
        if (pre_en) begin
            mem4[pre_a] <= pre_d;
            mem2[pre_a] <= pre_d;
        end else begin
            if (rwe4) mem4[ra4] <= rw4;
            if (rwe2) mem2[ra2] <= rw2;
        end
        mrd4 <= mem4[ra4];
        mrd2 <= mem2[ra2];
    end

    function automatic logic [13:0] addr_of(input int r);
        return r < 32 ? 14'(r) : 14'(32'h3FE0 + r - 32);
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s dut%0d cyc%0d got=%0h exp=%0h", tag, d ? 2 : 4, cyc, got, exp);
        end
    endtask

    task automatic req(input int i, input bit vv, input bit w, input logic [13:0] ad, input logic [7:0] dd);
        for (int d = 0; d < 2; d++) begin
            if (i < (d ? 2 : 4)) begin
                s_v[d][i] = vv;
                s_we[d][i] = w;
                s_a[d][i] = ad;
                s_wd[d][i] = dd;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int n, g, j;
            logic [3:0] er, ev;
            logic [7:0] ed;
            n = d ? 2 : 4;
            g = -1;
            j = -1;
            er = '0;
            ev = '0;
            ed = '0;
            if (!rstn) begin
                ptr[d] = 0;
                cur_we[d] = 0;
                cur_a[d] = '0;
                cur_wd[d] = '0;
                for (int k = rq.size() - 1; k >= 0; k--) if (rq[k].d == d) rq.delete(k);
            end else begin
                for (int k = n - 1; k >= 0; k--) if (s_v[d][(ptr[d] + k) % n]) g = (ptr[d] + k) % n;
            end
            if (g >= 0) er[g] = 1'b1;
            for (int k = rq.size() - 1; k >= 0; k--) if (rq[k].d == d) j = k;
            if (j >= 0 && rq[j].due == cyc) begin
                ev[rq[j].id] = 1'b1;
                ed = rq[j].data;
                rq.delete(j);
            end
            chk("req_ready", d, d ? {2'b0, rdy2} : rdy4, er);
            chk("rsp_valid", d, d ? {2'b0, rv2} : rv4, ev);
            chk("rsp_rdata", d, d ? rd2 : rd4, ed);
            chk("ram_we", d, d ? rwe2 : rwe4, cur_we[d]);
            chk("ram_addr", d, d ? ra2 : ra4, cur_a[d]);
            chk("ram_wdata", d, d ? rw2 : rw4, cur_wd[d]);
            g_last[d] = g;
            nxt_we[d] = 1'b0;
            nxt_a[d] = cur_a[d];
            nxt_wd[d] = cur_wd[d];
            if (g >= 0) begin
                ptr[d] = (g + 1) % n;
                nxt_we[d] = s_we[d][g];
                nxt_a[d] = s_a[d][g];
                nxt_wd[d] = s_wd[d][g];
                if (s_we[d][g]) ref_mem[d][s_a[d][g]] = s_wd[d][g];
                else rq.push_back('{d, cyc + 2, g, ref_mem[d][s_a[d][g]]});
            end
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            cur_we[d] = nxt_we[d];
            cur_a[d] = nxt_a[d];
            cur_wd[d] = nxt_wd[d];
        end
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < 4; i++) req(i, 0, 0, '0, '0);
        repeat (k) cycle();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0;
            g_last[d] = -1;
            cur_we[d] = 0;
            cur_a[d] = '0;
            cur_wd[d] = '0;
        end
        #1;
        for (int i = 0; i < 4; i++) req(i, 1, 0, 14'(i), 8'(i));
        pre_en = 1'b1;
        for (int r = 0; r < 64; r++) begin
            pre_a = addr_of(r);
            pre_d = pre_a[7:0];
            ref_mem[0][pre_a] = pre_d;
            ref_mem[1][pre_a] = pre_d;
            cycle();
        end
        pre_en = 1'b0;
        for (int i = 0; i < 4; i++) req(i, 0, 0, '0, '0);
        rstn = 1'b1;
        cycle();

        req(0, 1, 0, 14'h0000, 8'h00);
        cycle();
        idle(3);

        req(1, 1, 1, 14'h3FFF, 8'hA5);
        cycle();
        req(1, 0, 0, '0, '0);
        req(0, 1, 0, 14'h3FFF, 8'h00);
        cycle();
        idle(4);

        req(0, 1, 0, 14'h0005, 8'h00);
        cycle();
        req(0, 0, 0, '0, '0);
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        cycle();
        req(0, 1, 0, 14'h0010, 8'h00);
        req(1, 1, 0, 14'h0011, 8'h00);
        repeat (6) cycle();
        idle(3);

        req(1, 1, 0, 14'h0012, 8'h00);
        cycle();
        req(3, 1, 0, 14'h0013, 8'h00);
        repeat (3) cycle();
        idle(3);

        for (int k = 0; k < 8; k++) begin
            req(0, 1, 0, 14'(16 + k), 8'h00);
            cycle();
        end
        idle(3);

        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < (d ? 2 : 4); i++) begin
                    if (!s_v[d][i] || g_last[d] == i) begin
                        s_v[d][i] = $urandom_range(0, 9) < 6;
                        s_we[d][i] = $urandom_range(0, 2) == 0;
                        s_a[d][i] = addr_of($urandom_range(0, 63));
                        s_wd[d][i] = 8'($urandom);
                    end
                end
            end
            cycle();
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
